cpu_bus_responder: RTL and testbench

- Memory-side responder for the 6502 CPU bus. It answers `Addr_bus` reads with `Data_bus` and accepts CPU writes.
- Maps a 2 KB internal RAM, mirrored over $0000-$1FFF, and a PRG ROM window at $8000-$FFFF, which is fetched over an external port.
- Implements OAM DMA: a CPU write to $4014 stalls the CPU via `rdy` and copies one 256-byte page to the OAM write port.
- Replaces the bench-level program ROM once the CPU is integrated into the NES top.

---
 rtl/nes_pkg.sv | 34 +++
 rtl/cpu_bus_responder_oam_dma_ctrl.sv | 96 +++++++++
 rtl/cpu_bus_responder.sv | 118 +++++++++++
 tb/tb_cpu_bus_responder.sv | 396 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nes_pkg.sv
// nes_pkg
// Shared definitions for the NES CPU-side bus logic and the CPU benches:
// address-map constants, the OAM DMA state encoding, a few 6502 opcode
// constants, and address-region decode helpers.
package nes_pkg;

    localparam logic [15:0] RAM_TOP         = 16'h1FFF;
    localparam logic [15:0] PRG_BASE        = 16'h8000;
    localparam logic [15:0] DMA_REG_DEFAULT = 16'h4014;

    // Opcodes the CPU benches already refer to
    localparam logic [7:0] OP_BRK     = 8'h00;
    localparam logic [7:0] OP_JMP_ABS = 8'h4C;
    localparam logic [7:0] OP_STA_ABS = 8'h8D;
    localparam logic [7:0] OP_LDA_IMM = 8'hA9;
    localparam logic [7:0] OP_NOP     = 8'hEA;

    typedef enum logic [2:0] {
        DMA_IDLE  = 3'd0,
        DMA_HALT  = 3'd1,
        DMA_ALIGN = 3'd2,
        DMA_RD    = 3'd3,
        DMA_WR    = 3'd4
    } dma_state_e;

    function automatic logic is_ram(input logic [15:0] addr);
        return addr <= RAM_TOP;
    endfunction

    function automatic logic is_prg(input logic [15:0] addr);
        return addr >= PRG_BASE;
    endfunction

endpackage

// File: rtl/cpu_bus_responder_oam_dma_ctrl.sv
// oam_dma_ctrl
// OAM DMA sequencer. Stalls the CPU, then copies one 256-byte page into OAM
// with alternating read/write cycles. A one-cycle ALIGN slot is inserted when
// the bus parity is odd in the HALT cycle.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | CPU owns the bus, rdy=1, waiting for a write to the DMA register
// HALT  | CPU stalled, first DMA cycle; parity picks ALIGN or RD next
// ALIGN | one idle cycle to get onto the read phase
// RD    | read source byte {page, idx} through the parent's decoder
// WR    | pulse oam_we with the latched byte at oam_addr=idx, bump idx
//
// Ports:
//   clk_ph1, rst          clock, synchronous active-low reset
//   start_req, start_page CPU write to the DMA register and its data
//   src_rd, src_addr      source read request to the parent decoder
//   src_data              decoded source byte (valid while src_rd)
//   rdy, dma_busy         CPU stall / activity flags
//   oam_we/addr/wdata     OAM write port
module oam_dma_ctrl
    import nes_pkg::*;
(
    input  logic        clk_ph1,
    input  logic        rst,
    input  logic        start_req,
    input  logic [7:0]  start_page,
    input  logic [7:0]  src_data,
    output logic        src_rd,
    output logic [15:0] src_addr,
    output logic        rdy,
    output logic        dma_busy,
    output logic        oam_we,
    output logic [7:0]  oam_addr,
    output logic [7:0]  oam_wdata
);

    dma_state_e state_q, state_d;
    logic [7:0] page_q, page_d;
    logic [7:0] idx_q, idx_d;
    logic [7:0] wdata_q, wdata_d;
    logic       parity_q, parity_d;

    always_ff @(posedge clk_ph1) begin
        if (!rst) begin
            state_q  <= DMA_IDLE;
            page_q   <= 8'h00;
            idx_q    <= 8'h00;
            wdata_q  <= 8'h00;
            parity_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            page_q   <= page_d;
            idx_q    <= idx_d;
            wdata_q  <= wdata_d;
            parity_q <= parity_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        page_d   = page_q;
        idx_d    = idx_q;
        wdata_d  = wdata_q;
        parity_d = ~parity_q;
        case (state_q)
            DMA_IDLE: begin
                if (start_req) begin
                    page_d  = start_page;
                    state_d = DMA_HALT;
                end
            end
            DMA_HALT:  state_d = parity_q ? DMA_ALIGN : DMA_RD;
            DMA_ALIGN: state_d = DMA_RD;
            DMA_RD: begin
                wdata_d = src_data;
                state_d = DMA_WR;
            end
            DMA_WR: begin
                // idx wraps to 0 on the last byte, leaving it ready for the next run
                idx_d   = idx_q + 8'd1;
                state_d = (idx_q == 8'hFF) ? DMA_IDLE : DMA_RD;
            end
            default: state_d = DMA_IDLE;
        endcase
    end

    assign src_rd    = (state_q == DMA_RD);
    assign src_addr  = {page_q, idx_q};
    assign rdy       = (state_q == DMA_IDLE);
    assign dma_busy  = (state_q != DMA_IDLE);
    assign oam_we    = (state_q == DMA_WR);
    assign oam_addr  = idx_q;
    assign oam_wdata = wdata_q;

endmodule

// File: rtl/cpu_bus_responder.sv
// cpu_bus_responder
// Memory-side responder for the 6502 CPU bus: 2 KB internal RAM mirrored over
// $0000-$1FFF, PRG ROM window $8000-$FFFF fetched over an external port, and
// OAM DMA triggered by a CPU write to DMA_REG.
//
// Build option: CPU_OPEN_BUS_EN
//   defined   - unmapped reads and Data_bus during DMA return the last byte
//               seen on the bus (CPU read, CPU write or DMA read)
//   undefined - unmapped reads return 8'h00, Data_bus=8'h00 during DMA
//
// Ports:
//   clk_ph1, rst           clock, synchronous active-low reset
//   Addr_bus, rw, cpu_dout CPU address, direction (1=read), write data
//   Data_bus               read data to the CPU (combinational)
//   rdy                    0 stalls the CPU during DMA
//   prg_addr, prg_data     PRG ROM fetch port (data combinational to address)
//   oam_we/addr/wdata      OAM write port
//   dma_busy               high while DMA is active
module cpu_bus_responder
    import nes_pkg::*;
#(
    parameter int          RAM_AW  = 11,
    parameter logic [15:0] DMA_REG = DMA_REG_DEFAULT
) (
    input  logic        clk_ph1,
    input  logic        rst,
    input  logic [15:0] Addr_bus,
    input  logic        rw,
    input  logic [7:0]  cpu_dout,
    output logic [7:0]  Data_bus,
    output logic        rdy,
    output logic [14:0] prg_addr,
    input  logic [7:0]  prg_data,
    output logic        oam_we,
    output logic [7:0]  oam_addr,
    output logic [7:0]  oam_wdata,
    output logic        dma_busy
);

    logic [7:0]  ram_q [0:(1<<RAM_AW)-1];

    logic        src_rd;
    logic [15:0] src_addr;
    logic [15:0] rd_addr;
    logic [7:0]  rd_data;
    logic [7:0]  unmapped_data;
    logic [7:0]  busy_data;
    logic        ram_we;
    logic        start_req;

    // One decoder serves both the CPU and the DMA engine; DMA owns it only in RD.
    always_comb begin
        rd_addr = src_rd ? src_addr : Addr_bus;
        if (is_ram(rd_addr)) begin
            rd_data = ram_q[rd_addr[RAM_AW-1:0]];
        end else if (is_prg(rd_addr)) begin
            rd_data = prg_data;
        end else begin
            rd_data = unmapped_data;
        end
    end

    assign prg_addr = rd_addr[14:0];
    assign Data_bus = dma_busy ? busy_data : rd_data;

    // CPU writes land only while the CPU owns the bus.
    assign ram_we    = rst && !dma_busy && !rw && is_ram(Addr_bus);
    assign start_req = !rw && (Addr_bus == DMA_REG);

    always_ff @(posedge clk_ph1) begin
        if (ram_we) begin
            ram_q[Addr_bus[RAM_AW-1:0]] <= cpu_dout;
        end
    end

`ifdef CPU_OPEN_BUS_EN
    logic [7:0] open_bus_q, open_bus_d;

    always_comb begin
        open_bus_d = open_bus_q;
        if (src_rd) begin
            open_bus_d = rd_data;
        end else if (!dma_busy) begin
            open_bus_d = rw ? rd_data : cpu_dout;
        end
    end

    always_ff @(posedge clk_ph1) begin
        if (!rst) begin
            open_bus_q <= 8'h00;
        end else begin
            open_bus_q <= open_bus_d;
        end
    end

    assign unmapped_data = open_bus_q;
    assign busy_data     = open_bus_q;
`else
    assign unmapped_data = 8'h00;
    assign busy_data     = 8'h00;
`endif

    oam_dma_ctrl u_dma (
        .clk_ph1    (clk_ph1),
        .rst        (rst),
        .start_req  (start_req),
        .start_page (cpu_dout),
        .src_data   (rd_data),
        .src_rd     (src_rd),
        .src_addr   (src_addr),
        .rdy        (rdy),
        .dma_busy   (dma_busy),
        .oam_we     (oam_we),
        .oam_addr   (oam_addr),
        .oam_wdata  (oam_wdata)
    );

endmodule

// File: tb/tb_cpu_bus_responder.sv
module tb_cpu_bus_responder;

    logic        clk_ph1 = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] Addr_bus = 16'h8000;
    logic        rw = 1'b1;
    logic [7:0]  cpu_dout = 8'h00;
    logic [7:0]  Data_bus;
    logic        rdy;
    logic [14:0] prg_addr;
    logic [7:0]  prg_data;
    logic        oam_we;
    logic [7:0]  oam_addr;
    logic [7:0]  oam_wdata;
    logic        dma_busy;

    cpu_bus_responder dut (
        .clk_ph1   (clk_ph1),
        .rst       (rst),
        .Addr_bus  (Addr_bus),
        .rw        (rw),
        .cpu_dout  (cpu_dout),
        .Data_bus  (Data_bus),
        .rdy       (rdy),
        .prg_addr  (prg_addr),
        .prg_data  (prg_data),
        .oam_we    (oam_we),
        .oam_addr  (oam_addr),
        .oam_wdata (oam_wdata),
        .dma_busy  (dma_busy)
    );

    always #5 clk_ph1 = ~clk_ph1;

    // PRG ROM model: each byte holds the low byte of its address
    assign prg_data = prg_addr[7:0];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [7:0]  ram_m [2048];
    bit          ram_v [2048];
    logic [10:0] wq[$];
    logic [7:0]  bus_m = 8'h00;
    bit          par_m = 1'b0;

    always @(posedge clk_ph1) par_m <= rst ? ~par_m : 1'b0;

    // Observation of the DMA side, sampled mid-cycle
    int         stall_cnt = 0;
    int         pulse_cnt = 0;
    int         first_we_stall = 0;
    logic [7:0] got_addr[$];
    logic [7:0] got_data[$];

    always @(negedge clk_ph1) begin
        if (!rdy) stall_cnt++;
        if (oam_we) begin
            pulse_cnt++;
            if (pulse_cnt == 1) first_we_stall = stall_cnt;
            got_addr.push_back(oam_addr);
            got_data.push_back(oam_wdata);
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, actual=timeout required=finish");
        $fatal(1);
    end

    function automatic logic [7:0] model_read(input logic [15:0] a);
        if (a <= 16'h1FFF) return ram_m[a[10:0]];
        if (a >= 16'h8000) return a[7:0];
`ifdef CPU_OPEN_BUS_EN
        return bus_m;
`else
        return 8'h00;
`endif
    endfunction

    task automatic step();
        @(posedge clk_ph1);
        #1;
    endtask

    task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
        Addr_bus = a;
        rw       = 1'b0;
        cpu_dout = d;
        step();
        rw       = 1'b1;
        Addr_bus = 16'h8000;
        if (a <= 16'h1FFF) begin
            ram_m[a[10:0]] = d;
            if (!ram_v[a[10:0]]) wq.push_back(a[10:0]);
            ram_v[a[10:0]] = 1'b1;
        end
        bus_m = d;
    endtask

    task automatic do_read(input logic [15:0] a, output logic [7:0] d,
                           output logic r, output logic [14:0] pa);
        Addr_bus = a;
        rw       = 1'b1;
        #1;
        d  = Data_bus;
        r  = rdy;
        pa = prg_addr;
        step();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        step();
        step();
        n_checks++;
        if (rdy !== 1'b1) begin n_fail++; $display("FAIL reset_rdy: got %b want 1", rdy); end
        n_checks++;
        if (dma_busy !== 1'b0) begin n_fail++; $display("FAIL reset_dma_busy: got %b want 0", dma_busy); end
        n_checks++;
        if (oam_we !== 1'b0) begin n_fail++; $display("FAIL reset_oam_we: got %b want 0", oam_we); end
        n_checks++;
        if (oam_addr !== 8'h00) begin n_fail++; $display("FAIL reset_oam_addr: got %h want 00", oam_addr); end
        n_checks++;
        if (oam_wdata !== 8'h00) begin n_fail++; $display("FAIL reset_oam_wdata: got %h want 00", oam_wdata); end
        rst   = 1'b1;
        bus_m = 8'h00;
        step();
        bus_m = 8'h00;
    endtask

    task automatic test_ram_mirror();
        logic [15:0] addrs [4] = '{16'h0005, 16'h0805, 16'h1005, 16'h1805};
        logic [7:0]  d;
        logic        r;
        logic [14:0] pa;
        cpu_write(16'h0005, 8'h3C);
        foreach (addrs[k]) begin
            do_read(addrs[k], d, r, pa);
            n_checks++;
            if (d !== 8'h3C) begin n_fail++; $display("FAIL mirror_data @%h: got %h want 3c", addrs[k], d); end
            n_checks++;
            if (r !== 1'b1) begin n_fail++; $display("FAIL mirror_rdy @%h: got %b want 1", addrs[k], r); end
            bus_m = 8'h3C;
        end
    endtask

    task automatic test_rom_and_open_bus();
        logic [7:0]  d;
        logic        r;
        logic [14:0] pa;
        logic [7:0]  exp_unm;
        do_read(16'h8009, d, r, pa);
        n_checks++;
        if (pa !== 15'h0009) begin n_fail++; $display("FAIL rom_prg_addr: got %h want 0009", pa); end
        n_checks++;
        if (d !== 8'h09) begin n_fail++; $display("FAIL rom_data: got %h want 09", d); end
        bus_m = 8'h09;
        cpu_write(16'h0009, 8'h77);
        cpu_write(16'h8009, 8'h5A);
        do_read(16'h0009, d, r, pa);
        n_checks++;
        if (d !== 8'h77) begin n_fail++; $display("FAIL rom_write_ignored: got %h want 77", d); end
        bus_m = 8'h77;
        // unmapped read right after a ROM read
        do_read(16'h8009, d, r, pa);
        bus_m = 8'h09;
`ifdef CPU_OPEN_BUS_EN
        exp_unm = 8'h09;
`else
        exp_unm = 8'h00;
`endif
        do_read(16'h5000, d, r, pa);
        n_checks++;
        if (d !== exp_unm) begin n_fail++; $display("FAIL open_bus_5000: got %h want %h", d, exp_unm); end
        bus_m = exp_unm;
    endtask

    task automatic test_random_bus();
        logic [7:0]  d;
        logic        r;
        logic [14:0] pa;
        logic [15:0] a;
        logic [7:0]  exp;
        int          op;
        cpu_write({3'b000, 2'($urandom_range(0, 3)), 11'($urandom_range(0, 2047))}, 8'($urandom));
        for (int it = 0; it < 300; it++) begin
            op = int'($urandom_range(0, 4));
            case (op)
                0: cpu_write({3'b000, 2'($urandom_range(0, 3)), 11'($urandom_range(0, 2047))}, 8'($urandom));
                1: begin
                    a   = {3'b000, 2'($urandom_range(0, 3)), wq[$urandom_range(0, wq.size() - 1)]};
                    exp = model_read(a);
                    do_read(a, d, r, pa);
                    n_checks++;
                    if (d !== exp) begin n_fail++; $display("FAIL rand_ram_read @%h: got %h want %h", a, d, exp); end
                    bus_m = exp;
                end
                2: begin
                    a   = {1'b1, 15'($urandom)};
                    exp = model_read(a);
                    do_read(a, d, r, pa);
                    n_checks++;
                    if (d !== exp || pa !== a[14:0]) begin
                        n_fail++;
                        $display("FAIL rand_prg_read @%h: got data %h addr %h want data %h addr %h", a, d, pa, exp, a[14:0]);
                    end
                    bus_m = exp;
                end
                3: cpu_write({1'b1, 15'($urandom)}, 8'($urandom));
                default: begin
                    a   = 16'($urandom_range(16'h2000, 16'h7FFF));
                    exp = model_read(a);
                    do_read(a, d, r, pa);
                    n_checks++;
                    if (d !== exp || r !== 1'b1) begin
                        n_fail++;
                        $display("FAIL rand_unmapped @%h: got %h rdy %b want %h rdy 1", a, d, r, exp);
                    end
                    bus_m = exp;
                end
            endcase
        end
    endtask

    task automatic run_dma(input logic [7:0] page, input bit align, input string tag);
        logic [7:0]  exp_d [256];
        logic [15:0] noise_a [$];
        logic [7:0]  d;
        logic        r;
        logic [14:0] pa;
        logic [15:0] a;
        int          cnt;
        bit          rdy_dropped;
        for (int i = 0; i < 256; i++) exp_d[i] = model_read({page, 8'(i)});
        Addr_bus = 16'h8000;
        rw       = 1'b1;
        while (par_m == align) step();
        stall_cnt = 0;
        pulse_cnt = 0;
        first_we_stall = 0;
        got_addr.delete();
        got_data.delete();
        Addr_bus = 16'h4014;
        rw       = 1'b0;
        cpu_dout = page;
        step();
        n_checks++;
        if (rdy !== 1'b0 || dma_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_halt: got rdy %b busy %b want rdy 0 busy 1", tag, rdy, dma_busy);
        end
        // CPU bus activity during DMA, including a second trigger, must be ignored
        for (int k = 0; k < 40; k++) begin
            if (k == 5) begin
                Addr_bus = 16'h4014;
                cpu_dout = page ^ 8'h01;
            end else begin
                a = {3'b000, 2'($urandom_range(0, 3)), 3'b010, 8'($urandom)};
                noise_a.push_back(a);
                Addr_bus = a;
                cpu_dout = 8'($urandom);
            end
            rw = 1'b0;
`ifndef CPU_OPEN_BUS_EN
            if (k == 10) begin
                n_checks++;
                if (Data_bus !== 8'h00) begin n_fail++; $display("FAIL %s_busy_data: got %h want 00", tag, Data_bus); end
            end
`endif
            step();
        end
        Addr_bus = 16'h8000;
        rw       = 1'b1;
        cnt = 0;
        while (!rdy && cnt < 1000) begin step(); cnt++; end
        n_checks++;
        if (cnt >= 1000) begin n_fail++; $display("FAIL %s_timeout: rdy still %b want 1", tag, rdy); end
        n_checks++;
        if (stall_cnt != (align ? 514 : 513)) begin
            n_fail++;
            $display("FAIL %s_stall: got %0d want %0d", tag, stall_cnt, align ? 514 : 513);
        end
        n_checks++;
        if (pulse_cnt != 256) begin n_fail++; $display("FAIL %s_pulses: got %0d want 256", tag, pulse_cnt); end
        n_checks++;
        if (first_we_stall != (align ? 4 : 3)) begin
            n_fail++;
            $display("FAIL %s_first_we: got cycle %0d want %0d", tag, first_we_stall, align ? 4 : 3);
        end
        for (int i = 0; i < 256 && i < got_addr.size(); i++) begin
            n_checks++;
            if (got_addr[i] !== 8'(i) || got_data[i] !== exp_d[i]) begin
                n_fail++;
                $display("FAIL %s_oam[%0d]: got addr %h data %h want addr %h data %h",
                         tag, i, got_addr[i], got_data[i], 8'(i), exp_d[i]);
            end
        end
        rdy_dropped = 1'b0;
        for (int k = 0; k < 6; k++) begin
            if (rdy !== 1'b1) rdy_dropped = 1'b1;
            step();
        end
        n_checks++;
        if (rdy_dropped || pulse_cnt != 256) begin
            n_fail++;
            $display("FAIL %s_retrigger: got rdy_dropped %b pulses %0d want 0 and 256", tag, rdy_dropped, pulse_cnt);
        end
        bus_m = 8'h00;
        for (int k = 0; k < 4; k++) begin
            a = noise_a[k];
            do_read(a, d, r, pa);
            n_checks++;
            if (d !== model_read(a)) begin
                n_fail++;
                $display("FAIL %s_no_cpu_write @%h: got %h want %h", tag, a, d, model_read(a));
            end
            bus_m = model_read(a);
        end
    endtask

    task automatic test_dma_ram_even();
        for (int i = 0; i < 256; i++) cpu_write(16'h0200 + 16'(i), 8'(i) ^ 8'hA5);
        run_dma(8'h02, 1'b0, "dma_even");
    endtask

    task automatic test_dma_ram_odd();
        run_dma(8'h02, 1'b1, "dma_odd");
    endtask

    task automatic test_dma_prg();
        run_dma(8'($urandom_range(8'h80, 8'hFF)), 1'($urandom), "dma_prg");
        run_dma(8'h12, 1'($urandom), "dma_mirror");
    endtask

    task automatic test_reset_mid_dma();
        int cnt;
        int snap_pulses;
        int snap_stall;
        Addr_bus  = 16'h8000;
        rw        = 1'b1;
        stall_cnt = 0;
        pulse_cnt = 0;
        got_addr.delete();
        got_data.delete();
        Addr_bus = 16'h4014;
        rw       = 1'b0;
        cpu_dout = 8'h02;
        step();
        Addr_bus = 16'h8000;
        rw       = 1'b1;
        cnt = 0;
        while (pulse_cnt < 100 && cnt < 2000) begin
            @(negedge clk_ph1);
            #1;
            cnt++;
        end
        n_checks++;
        if (pulse_cnt != 100) begin n_fail++; $display("FAIL rstdma_reach100: got %0d pulses want 100", pulse_cnt); end
        rst = 1'b0;
        step();
        n_checks++;
        if (rdy !== 1'b1 || dma_busy !== 1'b0 || oam_we !== 1'b0) begin
            n_fail++;
            $display("FAIL rstdma_abort: got rdy %b busy %b we %b want 1 0 0", rdy, dma_busy, oam_we);
        end
        rst = 1'b1;
        snap_pulses = pulse_cnt;
        snap_stall  = stall_cnt;
        for (int k = 0; k < 600; k++) step();
        n_checks++;
        if (pulse_cnt != snap_pulses || stall_cnt != snap_stall) begin
            n_fail++;
            $display("FAIL rstdma_quiet: got pulses %0d stall %0d want %0d %0d",
                     pulse_cnt, stall_cnt, snap_pulses, snap_stall);
        end
        bus_m = 8'h00;
        run_dma(8'h02, 1'($urandom), "dma_restart");
    endtask

    initial begin
        test_reset();
        test_ram_mirror();
        test_rom_and_open_bus();
        test_random_bus();
        test_dma_ram_even();
        test_dma_ram_odd();
        test_dma_prg();
        test_reset_mid_dma();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
